// File: rtl/hasti_to_poci_bridge_if.sv
// -----------------------------------------------------------------------------
// if_poci : POCI peripheral bus bundle (APB-like, word-only).
//
// Signals
//   psel     master -> slave  slave selected (SETUP and ACCESS)
//   penable  master -> slave  ACCESS phase marker
//   pwrite   master -> slave  1 = write
//   paddr    master -> slave  byte address, ADDR_WIDTH bits
//   pwdata   master -> slave  write data, 32 bits
//   prdata   slave -> master  read data, 32 bits
//   pready   slave -> master  ACCESS completes in this cycle
//   pslverr  slave -> master  transfer error, valid with pready
//
// Modports: m (bridge / master side), s (peripheral side).
// -----------------------------------------------------------------------------
interface if_poci #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport m (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport s (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/hasti_to_poci_bridge.sv
// -----------------------------------------------------------------------------
// hasti_to_poci_bridge : turns each single HASTI (AHB-lite) transfer from the
// zscale data bus into one POCI SETUP/ACCESS transfer, stalling the core with
// hready until the peripheral answers (or the ACCESS timeout expires).
//
// Parameters
//   ADDR_WIDTH      width of haddr / paddr
//   TIMEOUT_CYCLES  max ACCESS cycles waiting for pready, 0 = wait forever
//
// Ports
//   pclk     single clock for both buses
//   presetn  asynchronous active-low reset
//   hsel, haddr, hwrite, htrans, hsize   HASTI address phase (hsize unused)
//   hwdata                               HASTI write data (data phase)
//   hrdata, hready, hresp                HASTI response
//   bus      POCI master modport
//
// Build option
//   POCI_BRIDGE_ERR_EN  when defined, pslverr or a timeout produce the
//                       two-cycle HASTI ERROR response (ERR1/ERR2); when
//                       undefined, pslverr is ignored and hresp stays 0.
// -----------------------------------------------------------------------------
module hasti_to_poci_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hsize,
    input  logic [31:0]           hwdata,
    output logic [31:0]           hrdata,
    output logic                  hready,
    output logic                  hresp,
    if_poci.m                     bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Counter value seen during the last permitted ACCESS cycle.
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        DONE   = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_t;

    state_t                state;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [31:0]           pwdata_q;
    logic [31:0]           hrdata_q;
    logic                  hready_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt;
    logic                  accept;
    logic                  timeout_hit;

    assign accept      = hsel & htrans[1] & hready_q;
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt == TO_LAST);

    // Width/protocol inputs that POCI has no use for.
`ifdef POCI_BRIDGE_ERR_EN
    logic unused_inputs;
    assign unused_inputs = &{1'b0, hsize, htrans[0]};
`else
    logic unused_inputs;
    assign unused_inputs = &{1'b0, hsize, htrans[0], bus.pslverr};
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            hrdata_q  <= '0;
            hready_q  <= 1'b1;
            err_q     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                // Every state in which hready is high can accept the next
                // address phase; otherwise drop back to IDLE.
                IDLE, DONE, ERR2: begin
                    cnt       <= '0;
                    err_q     <= 1'b0;
                    penable_q <= 1'b0;
                    psel_q    <= accept;
                    hready_q  <= ~accept;
                    if (accept) begin
                        state    <= SETUP;
                        paddr_q  <= haddr;
                        pwrite_q <= hwrite;
                    end else begin
                        state    <= IDLE;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    penable_q <= 1'b1;
                    pwdata_q  <= hwdata;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        cnt       <= '0;
`ifdef POCI_BRIDGE_ERR_EN
                        if (bus.pslverr) begin
                            state    <= ERR1;
                            err_q    <= 1'b1;
                            hrdata_q <= '0;
                        end else
`endif
                        begin
                            state    <= DONE;
                            hready_q <= 1'b1;
                            if (!pwrite_q) begin
                                hrdata_q <= bus.prdata;
                            end
                        end
                    end else if (timeout_hit) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        cnt       <= '0;
                        hrdata_q  <= '0;
`ifdef POCI_BRIDGE_ERR_EN
                        state     <= ERR1;
                        err_q     <= 1'b1;
`else
                        state     <= DONE;
                        hready_q  <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // First ERROR cycle: hold the core one more cycle with hresp=1.
                ERR1: begin
                    state    <= ERR2;
                    hready_q <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    hready_q  <= 1'b1;
                    err_q     <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

    assign bus.psel    = psel_q;
    assign bus.penable = penable_q;
    assign bus.pwrite  = pwrite_q;
    assign bus.paddr   = paddr_q;
    // The slave may latch write data during SETUP, before pwdata_q is loaded.
    assign bus.pwdata  = (state == SETUP) ? hwdata : pwdata_q;

    assign hrdata = hrdata_q;
    assign hready = hready_q;
    assign hresp  = err_q;

endmodule

// File: tb/tb_hasti_to_poci_bridge.sv
module tb_hasti_to_poci_bridge;

    localparam int TO = 8;
`ifdef POCI_BRIDGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [1:0]  T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10;

    logic        pclk;
    logic        presetn;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    if_poci #(.ADDR_WIDTH(32)) bus ();

    hasti_to_poci_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .hsel    (hsel),
        .haddr   (haddr),
        .hwrite  (hwrite),
        .htrans  (htrans),
        .hsize   (hsize),
        .hwdata  (hwdata),
        .hrdata  (hrdata),
        .hready  (hready),
        .hresp   (hresp),
        .bus     (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Peripheral: four word registers (ledg, ledr, hex, spare).
    logic [31:0] slave_mem [0:3] = '{default: 32'h0};
    int          s_waits = 0;
    bit          s_stuck = 1'b0;
    bit          s_err   = 1'b0;
    int          acc_cnt = 0;
    logic        in_access;

    assign in_access   = bus.psel && bus.penable;
    assign bus.pready  = in_access && !s_stuck && (acc_cnt >= s_waits);
    assign bus.prdata  = slave_mem[bus.paddr[3:2]];
    assign bus.pslverr = bus.pready && s_err;

    always @(posedge pclk) begin
        if (in_access && !bus.pready) acc_cnt <= acc_cnt + 1;
        else                          acc_cnt <= 0;
        if (in_access && bus.pready && bus.pwrite && !s_err)
            slave_mem[bus.paddr[3:2]] <= bus.pwdata;
    end

    // Reference model: what the peripheral holds and what hrdata shows.
    logic [31:0] ref_mem [0:3] = '{default: 32'h0};
    logic [31:0] last_hrdata = 32'h0;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One HASTI transfer. If predriven, the address phase is already on the
    // bus (chained from the previous call). If chain, the next address phase
    // is presented in the cycle where this transfer completes.
    task automatic do_xfer(input bit wr, input int idx, input logic [31:0] data,
                           input int waits, input bit stuck, input bit slverr,
                           input bit predriven, input bit chain,
                           input bit nwr, input int nidx);
        logic [31:0] addr;
        bit          e;
        int          exp_low;
        logic [31:0] exp_rd;
        int          low;
        bit          done;
        addr    = BASE + 32'(idx) * 4;
        e       = ERR_EN && (stuck || slverr);
        exp_low = (stuck ? TO + 1 : waits + 2) + (e ? 1 : 0);
        if (stuck || e)  exp_rd = 32'h0;
        else if (wr)     exp_rd = last_hrdata;
        else             exp_rd = ref_mem[idx];

        if (!predriven) begin
            @(negedge pclk);
            hsel = 1'b1; htrans = T_NONSEQ; haddr = addr; hwrite = wr; hsize = 3'b010;
        end
        s_waits = waits; s_stuck = stuck; s_err = slverr;
        @(posedge pclk);
        #1;
        hwdata = data;
        hsel   = 1'b0; htrans = T_IDLE;
        haddr  = $urandom; hwrite = $urandom_range(0, 1);

        low  = 0;
        done = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge pclk);
            if (hready === 1'b1) begin
                done = 1'b1;
                break;
            end
            low++;
            if (e && n == exp_low) begin
                chk("err1_hresp", hresp, 1'b1);
                chk("err1_psel", bus.psel, 1'b0);
            end else if (n == 1) begin
                chk("setup_psel", bus.psel, 1'b1);
                chk("setup_penable", bus.penable, 1'b0);
                chk("setup_paddr", bus.paddr, addr);
                if (wr) chk("setup_pwdata", bus.pwdata, data);
            end else begin
                chk("access_psel", bus.psel, 1'b1);
                chk("access_penable", bus.penable, 1'b1);
                chk("access_paddr", bus.paddr, addr);
            end
        end
        chk("hready_seen", 32'(done), 32'd1);
        chk("stall_cycles", low, exp_low);
        chk("done_hresp", hresp, e);
        chk("done_hrdata", hrdata, exp_rd);
        chk("done_psel", bus.psel, 1'b0);

        if (wr && !stuck && !slverr) ref_mem[idx] = data;
        last_hrdata = exp_rd;

        if (chain) begin
            hsel = 1'b1; htrans = T_NONSEQ; haddr = BASE + 32'(nidx) * 4; hwrite = nwr;
        end
    endtask

    typedef struct {
        bit          wr;
        int          idx;
        logic [31:0] data;
        int          waits;
        bit          stuck;
        bit          slverr;
        bit          chain;
    } xfer_t;

    xfer_t rt [20];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        presetn = 1'b0;
        hsel = 1'b0; haddr = 32'h0; hwrite = 1'b0; htrans = T_IDLE;
        hsize = 3'b010; hwdata = 32'h0;

        // Reset state.
        repeat (2) @(negedge pclk);
        chk("rst_psel", bus.psel, 1'b0);
        chk("rst_penable", bus.penable, 1'b0);
        chk("rst_pwrite", bus.pwrite, 1'b0);
        chk("rst_paddr", bus.paddr, 32'h0);
        chk("rst_pwdata", bus.pwdata, 32'h0);
        chk("rst_hready", hready, 1'b1);
        chk("rst_hresp", hresp, 1'b0);
        chk("rst_hrdata", hrdata, 32'h0);
        presetn = 1'b1;

        // Write 0xA5 to ledg with a zero-wait slave.
        do_xfer(1'b1, 0, 32'h0000_00A5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("slave_ledg", slave_mem[0], 32'h0000_00A5);

        // Write 0x3FF to ledr, read it back.
        do_xfer(1'b1, 1, 32'h0000_03FF, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        do_xfer(1'b0, 1, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("read_ledr", hrdata, 32'h0000_03FF);

        // Slave waits 4 ACCESS cycles.
        do_xfer(1'b0, 0, 32'h0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Back-to-back writes: hex then ledg.
        do_xfer(1'b1, 2, 32'h0000_1234, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        do_xfer(1'b1, 0, 32'h0000_005A, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("slave_hex", slave_mem[2], 32'h0000_1234);
        chk("slave_ledg2", slave_mem[0], 32'h0000_005A);

        // htrans BUSY with hsel high: no transfer.
        @(negedge pclk);
        hsel = 1'b1; htrans = T_BUSY; haddr = BASE;
        repeat (2) begin
            @(negedge pclk);
            chk("busy_psel", bus.psel, 1'b0);
            chk("busy_hready", hready, 1'b1);
        end
        hsel = 1'b0; htrans = T_IDLE;

        // Timeout: read and write with pready stuck low.
        do_xfer(1'b0, 1, 32'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        do_xfer(1'b1, 3, 32'hDEAD_BEEF, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        // Slave error on a read.
        do_xfer(1'b0, 1, 32'h0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Randomized transfers, some chained back-to-back.
        foreach (rt[i]) begin
            rt[i].wr     = $urandom_range(0, 1);
            rt[i].idx    = $urandom_range(0, 3);
            rt[i].data   = $urandom;
            rt[i].waits  = $urandom_range(0, 3);
            rt[i].stuck  = ($urandom_range(0, 9) == 0);
            rt[i].slverr = ($urandom_range(0, 7) == 0);
            rt[i].chain  = ($urandom_range(0, 2) == 0);
        end
        for (int i = 0; i < 20; i++) begin
            bit nxt_chain;
            nxt_chain = (i < 19) && rt[i+1].chain;
            do_xfer(rt[i].wr, rt[i].idx, rt[i].data, rt[i].waits, rt[i].stuck,
                    rt[i].slverr, (i > 0) && rt[i].chain, nxt_chain,
                    (i < 19) ? rt[i+1].wr : 1'b0, (i < 19) ? rt[i+1].idx : 0);
        end

        // Asynchronous reset in the middle of ACCESS.
        @(negedge pclk);
        hsel = 1'b1; htrans = T_NONSEQ; haddr = BASE + 32'h4; hwrite = 1'b0;
        s_stuck = 1'b1; s_err = 1'b0; s_waits = 0;
        @(posedge pclk);
        #1;
        hsel = 1'b0; htrans = T_IDLE;
        repeat (3) @(negedge pclk);
        chk("pre_rst_penable", bus.penable, 1'b1);
        #2;
        presetn = 1'b0;
        #1;
        chk("arst_psel", bus.psel, 1'b0);
        chk("arst_penable", bus.penable, 1'b0);
        chk("arst_hready", hready, 1'b1);
        chk("arst_hresp", hresp, 1'b0);
        chk("arst_hrdata", hrdata, 32'h0);
        last_hrdata = 32'h0;
        @(negedge pclk);
        presetn = 1'b1;
        s_stuck = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            chk("post_rst_hready", hready, 1'b1);
            chk("post_rst_psel", bus.psel, 1'b0);
        end
        do_xfer(1'b1, 3, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        do_xfer(1'b0, 3, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("post_rst_read", hrdata, 32'h0BAD_F00D);

        repeat (2) @(negedge pclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
